// File: rtl/addsub_chk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : addsub_chk_pkg
// Description : Shared types and helpers for the add/sub sweep checker.
//               Holds the checker state encoding, the statistics counter
//               width and the golden add/sub reference function.
// Revision    : 1.0 - initial release
// ============================================================================
package addsub_chk_pkg;

    // Width of vec_count / err_count and of the internal loop indices.
    localparam int c_cnt_w = 16;

    // Widest operand the reference function supports; callers sign-extend
    // their WIDTH-bit operands up to this width before calling it.
    localparam int c_max_w = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRIVE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Golden model. a_sx / b_sx are the operands sign-extended from w bits
    // to c_max_w bits. Because the operands are sign-extended, the
    // (c_max_w+1)-bit result r holds the w+1-bit two's-complement result in
    // its low bits, so bit w is the extended sign and bit w-1 the result
    // sign; they differ exactly on signed overflow.
    // Returns {ovf, r[c_max_w-1:0]}; the sum/difference is in the low w bits.
    function automatic logic [c_max_w:0] addsub_ref(
        input logic [c_max_w-1:0] a_sx,
        input logic [c_max_w-1:0] b_sx,
        input logic               op,
        input logic [5:0]         w
    );
        logic [c_max_w:0] r;
        logic             ovf;
        if (op) begin
            r = {a_sx[c_max_w-1], a_sx} - {b_sx[c_max_w-1], b_sx};
        end else begin
            r = {a_sx[c_max_w-1], a_sx} + {b_sx[c_max_w-1], b_sx};
        end
        ovf = r[w] ^ r[w - 6'd1];
        return {ovf, r[c_max_w-1:0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/addsub_ref_model.sv
`default_nettype none
// ============================================================================
// Module      : addsub_ref_model
// Description : Combinational wrapper around addsub_ref. Produces the
//               expected sum/difference and signed-overflow flag for a
//               WIDTH-bit two's-complement add (op=0) or subtract A-B (op=1).
// Ports       : a, b     - operands (WIDTH bits)
//               op       - 0 = add, 1 = subtract
//               exp_s    - expected result (WIDTH bits)
//               exp_ovf  - expected signed-overflow flag
// Revision    : 1.0 - initial release
// ============================================================================
module addsub_ref_model
    import addsub_chk_pkg::*;
#(
    parameter int WIDTH = 8     // 1 .. c_max_w
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op,
    output logic [WIDTH-1:0] exp_s,
    output logic             exp_ovf
);

    logic signed [WIDTH-1:0] w_a_signed;
    logic signed [WIDTH-1:0] w_b_signed;
    logic [c_max_w-1:0]      w_a_sx;
    logic [c_max_w-1:0]      w_b_sx;
    logic [c_max_w:0]        w_res;

    assign w_a_signed = a;
    assign w_b_signed = b;
    // Size cast of a signed value sign-extends.
    assign w_a_sx     = c_max_w'(w_a_signed);
    assign w_b_sx     = c_max_w'(w_b_signed);
    assign w_res      = addsub_ref(w_a_sx, w_b_sx, op, 6'(WIDTH));
    assign exp_s      = w_res[WIDTH-1:0];
    assign exp_ovf    = w_res[c_max_w];

    // Bits above WIDTH are only sign copies; sink them explicitly.
    if (WIDTH < c_max_w) begin : g_unused_hi
        logic w_unused_hi;
        assign w_unused_hi = ^w_res[c_max_w-1:WIDTH];
    end

endmodule
`default_nettype wire

// File: rtl/addsub_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module      : addsub_sweep_checker
// Description : BIST engine for an N-bit two's-complement adder/subtractor.
//               Sweeps A (incrementing) x B (decrementing) for add then
//               subtract, samples the DUT result after SETTLE cycles,
//               compares it with the golden model and accumulates
//               vector/error counts plus the first failing vector.
// Ports       : clk, rst          - clock, async active-high reset
//               start             - begins a sweep from IDLE or DONE
//               drv_a/drv_b       - operands driven to the DUT
//               drv_optype        - 0 = add, 1 = subtract (A-B)
//               dut_s/dut_overflow- DUT result and overflow flag
//               busy/done/pass    - sweep status
//               vec_count         - vectors checked
//               err_count         - mismatches (saturating)
//               fail_a/b/op       - first failing vector of the sweep
// Revision    : 1.0 - initial release
// ============================================================================
module addsub_sweep_checker
    import addsub_chk_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int A_FIRST = 1,
    parameter int A_COUNT = 4,
    parameter int B_FIRST = 128,
    parameter int B_COUNT = 4,
    parameter int SETTLE  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [WIDTH-1:0]   drv_a,
    output logic [WIDTH-1:0]   drv_b,
    output logic               drv_optype,
    input  logic [WIDTH-1:0]   dut_s,
    input  logic               dut_overflow,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [c_cnt_w-1:0] vec_count,
    output logic [c_cnt_w-1:0] err_count,
    output logic [WIDTH-1:0]   fail_a,
    output logic [WIDTH-1:0]   fail_b,
    output logic               fail_op
);

    localparam logic [WIDTH-1:0]   c_a_first     = WIDTH'(A_FIRST);
    localparam logic [WIDTH-1:0]   c_b_first     = WIDTH'(B_FIRST);
    localparam logic [c_cnt_w-1:0] c_a_last      = c_cnt_w'(A_COUNT - 1);
    localparam logic [c_cnt_w-1:0] c_b_last      = c_cnt_w'(B_COUNT - 1);
    localparam logic [c_cnt_w-1:0] c_settle_last = c_cnt_w'(SETTLE - 1);
    localparam logic [c_cnt_w-1:0] c_sat         = '1;
    // An empty grid finishes without checking anything.
    localparam logic               c_empty       = (A_COUNT == 0) || (B_COUNT == 0);
    localparam logic               c_no_settle   = (SETTLE == 0);

    state_t             r_state;
    logic               r_op;
    logic [c_cnt_w-1:0] r_a_idx;
    logic [c_cnt_w-1:0] r_b_idx;
    logic [WIDTH-1:0]   r_cur_a;
    logic [WIDTH-1:0]   r_cur_b;
    logic [c_cnt_w-1:0] r_settle;

    logic [WIDTH-1:0]   w_exp_s;
    logic               w_exp_ovf;
    logic               w_mismatch;
    logic [c_cnt_w-1:0] w_err_next;
    logic               w_last_a;
    logic               w_last_b;

    // Golden model looks at the registered operands, which stay stable
    // from DRIVE through CHECK.
    addsub_ref_model #(
        .WIDTH (WIDTH)
    ) u_ref (
        .a       (drv_a),
        .b       (drv_b),
        .op      (drv_optype),
        .exp_s   (w_exp_s),
        .exp_ovf (w_exp_ovf)
    );

    assign w_mismatch = (dut_s != w_exp_s) || (dut_overflow != w_exp_ovf);
    assign w_err_next = (w_mismatch && (err_count != c_sat)) ? err_count + 1'b1
                                                              : err_count;
    assign w_last_a   = (r_a_idx == c_a_last);
    assign w_last_b   = (r_b_idx == c_b_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_op       <= 1'b0;
            r_a_idx    <= '0;
            r_b_idx    <= '0;
            r_cur_a    <= '0;
            r_cur_b    <= '0;
            r_settle   <= '0;
            drv_a      <= '0;
            drv_b      <= '0;
            drv_optype <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            vec_count  <= '0;
            err_count  <= '0;
            fail_a     <= '0;
            fail_b     <= '0;
            fail_op    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        vec_count <= '0;
                        err_count <= '0;
                        fail_a    <= '0;
                        fail_b    <= '0;
                        fail_op   <= 1'b0;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        busy      <= 1'b1;
                        r_op      <= 1'b0;
                        r_a_idx   <= '0;
                        r_b_idx   <= '0;
                        r_cur_a   <= c_a_first;
                        r_cur_b   <= c_b_first;
                        r_state   <= ST_DRIVE;
                    end
                end

                ST_DRIVE: begin
                    if (c_empty) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= (err_count == '0);
                        r_state <= ST_DONE;
                    end else begin
                        drv_a      <= r_cur_a;
                        drv_b      <= r_cur_b;
                        drv_optype <= r_op;
                        r_settle   <= '0;
                        r_state    <= c_no_settle ? ST_CHECK : ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (r_settle == c_settle_last) begin
                        r_state <= ST_CHECK;
                    end else begin
                        r_settle <= r_settle + 1'b1;
                    end
                end

                ST_CHECK: begin
                    vec_count <= vec_count + 1'b1;
                    err_count <= w_err_next;
                    // err_count==0 marks the first error since start cleared it.
                    if (w_mismatch && (err_count == '0)) begin
                        fail_a  <= drv_a;
                        fail_b  <= drv_b;
                        fail_op <= drv_optype;
                    end
                    r_state <= ST_DRIVE;
                    // B innermost, then A, then optype; operands wrap mod 2^WIDTH.
                    if (w_last_b) begin
                        r_b_idx <= '0;
                        r_cur_b <= c_b_first;
                        if (w_last_a) begin
                            r_a_idx <= '0;
                            r_cur_a <= c_a_first;
                            if (r_op) begin
                                busy    <= 1'b0;
                                done    <= 1'b1;
                                pass    <= (w_err_next == '0);
                                r_state <= ST_DONE;
                            end else begin
                                r_op <= 1'b1;
                            end
                        end else begin
                            r_a_idx <= r_a_idx + 1'b1;
                            r_cur_a <= r_cur_a + 1'b1;
                        end
                    end else begin
                        r_b_idx <= r_b_idx + 1'b1;
                        r_cur_b <= r_cur_b - 1'b1;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_addsub_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_addsub_sweep_checker
// Description : Directed self-checking bench for addsub_sweep_checker.
//               Three checker instances: default grid (with a behavioural
//               adder/subtractor that can have its overflow stuck at 0), a
//               short wrapping grid with no settle time, and an empty grid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_addsub_sweep_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // ---------------- main instance (default parameters) ----------------
    logic        start_m = 1'b0;
    logic [7:0]  a_m, b_m, s_m, fa_m, fb_m;
    logic        op_m, ovf_m, ovf_raw_m, busy_m, done_m, pass_m, fop_m;
    logic [15:0] vec_m, err_m;
    logic        stuck_ovf = 1'b0;

    // Independent behavioural DUT: integer arithmetic, overflow by range.
    function automatic logic [8:0] bench_addsub(input logic [7:0] a, input logic [7:0] b,
                                                input logic op);
        int sa, sb, r;
        logic ovf;
        sa  = $signed(a);
        sb  = $signed(b);
        r   = op ? (sa - sb) : (sa + sb);
        ovf = (r > 127) || (r < -128);
        return {ovf, r[7:0]};
    endfunction

    assign {ovf_raw_m, s_m} = bench_addsub(a_m, b_m, op_m);
    assign ovf_m            = ovf_raw_m & ~stuck_ovf;

    addsub_sweep_checker u_main (
        .clk(clk), .rst(rst), .start(start_m),
        .drv_a(a_m), .drv_b(b_m), .drv_optype(op_m),
        .dut_s(s_m), .dut_overflow(ovf_m),
        .busy(busy_m), .done(done_m), .pass(pass_m),
        .vec_count(vec_m), .err_count(err_m),
        .fail_a(fa_m), .fail_b(fb_m), .fail_op(fop_m)
    );

    // ---------------- short wrapping grid, SETTLE=0 ----------------
    logic        start_w = 1'b0;
    logic [7:0]  a_w, b_w, s_w, fa_w, fb_w;
    logic        op_w, ovf_w, busy_w, done_w, pass_w, fop_w;
    logic [15:0] vec_w, err_w;

    assign {ovf_w, s_w} = bench_addsub(a_w, b_w, op_w);

    addsub_sweep_checker #(
        .WIDTH(8), .A_FIRST(1), .A_COUNT(4), .B_FIRST(1), .B_COUNT(3), .SETTLE(0)
    ) u_wrap (
        .clk(clk), .rst(rst), .start(start_w),
        .drv_a(a_w), .drv_b(b_w), .drv_optype(op_w),
        .dut_s(s_w), .dut_overflow(ovf_w),
        .busy(busy_w), .done(done_w), .pass(pass_w),
        .vec_count(vec_w), .err_count(err_w),
        .fail_a(fa_w), .fail_b(fb_w), .fail_op(fop_w)
    );

    // ---------------- empty grid, A_COUNT=0 ----------------
    logic        start_e = 1'b0;
    logic [7:0]  a_e, b_e, s_e, fa_e, fb_e;
    logic        op_e, ovf_e, busy_e, done_e, pass_e, fop_e;
    logic [15:0] vec_e, err_e;

    assign {ovf_e, s_e} = bench_addsub(a_e, b_e, op_e);

    addsub_sweep_checker #(
        .A_COUNT(0)
    ) u_empty (
        .clk(clk), .rst(rst), .start(start_e),
        .drv_a(a_e), .drv_b(b_e), .drv_optype(op_e),
        .dut_s(s_e), .dut_overflow(ovf_e),
        .busy(busy_e), .done(done_e), .pass(pass_e),
        .vec_count(vec_e), .err_count(err_e),
        .fail_a(fa_e), .fail_b(fb_e), .fail_op(fop_e)
    );

    // ---------------- standalone reference model ----------------
    logic [7:0] ref_a = '0, ref_b = '0, ref_s;
    logic       ref_op = 1'b0, ref_ovf;

    addsub_ref_model #(.WIDTH(8)) u_ref (
        .a(ref_a), .b(ref_b), .op(ref_op), .exp_s(ref_s), .exp_ovf(ref_ovf)
    );

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait for done on the main instance; n = edges after the start edge.
    task automatic wait_done_main(output int n, output bit timeout);
        n = 0;
        timeout = 1'b0;
        while (!done_m) begin
            step();
            n++;
            if (n > 400) begin
                timeout = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_main();
        start_m = 1'b1;
        step();
        start_m = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        total_cnt++;
        if ({a_m, b_m, op_m, busy_m, done_m, pass_m, vec_m, err_m, fa_m, fb_m, fop_m} !== '0)
            $display("FAIL reset_outputs: got a=%h b=%h op=%b busy=%b done=%b pass=%b vec=%0d err=%0d, want all 0",
                     a_m, b_m, op_m, busy_m, done_m, pass_m, vec_m, err_m);
        else pass_cnt++;
        rst = 1'b0;
        step();
        total_cnt++;
        if (busy_m !== 1'b0 || done_m !== 1'b0)
            $display("FAIL idle_after_reset: busy=%b done=%b, want 0 0", busy_m, done_m);
        else pass_cnt++;
    endtask

    task automatic test_spot();
        logic [7:0] va [6] = '{8'h01, 8'h01, 8'h04, 8'h7F, 8'h80, 8'hFF};
        logic [7:0] vb [6] = '{8'h80, 8'h80, 8'h7D, 8'h01, 8'h01, 8'h01};
        logic       vo [6] = '{1'b1,  1'b0,  1'b0,  1'b0,  1'b1,  1'b0};
        logic [7:0] es [6] = '{8'h81, 8'h81, 8'h81, 8'h80, 8'h7F, 8'h00};
        logic       eo [6] = '{1'b1,  1'b0,  1'b1,  1'b1,  1'b1,  1'b0};
        for (int i = 0; i < 6; i++) begin
            ref_a  = va[i];
            ref_b  = vb[i];
            ref_op = vo[i];
            #1;
            total_cnt++;
            if (ref_s !== es[i] || ref_ovf !== eo[i])
                $display("FAIL spot_%0d: a=%h b=%h op=%b got s=%h ovf=%b want s=%h ovf=%b",
                         i, va[i], vb[i], vo[i], ref_s, ref_ovf, es[i], eo[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_clean_sweep();
        int n;
        bit to;
        pulse_main();
        total_cnt++;
        if (busy_m !== 1'b1) $display("FAIL busy_after_start: got %b want 1", busy_m);
        else pass_cnt++;
        wait_done_main(n, to);
        // 32 vectors * 3 cycles after the start edge, plus the start edge.
        total_cnt++;
        if (to || (n + 1) != 97) $display("FAIL sweep_latency: got %0d edges (timeout=%b) want 97", n + 1, to);
        else pass_cnt++;
        total_cnt++;
        if (vec_m !== 16'd32 || err_m !== 16'd0)
            $display("FAIL clean_counts: got vec=%0d err=%0d want 32 0", vec_m, err_m);
        else pass_cnt++;
        total_cnt++;
        if (pass_m !== 1'b1 || busy_m !== 1'b0)
            $display("FAIL clean_status: got pass=%b busy=%b want 1 0", pass_m, busy_m);
        else pass_cnt++;
    endtask

    // With overflow stuck at 0 every overflowing vector of the default grid
    // fails. Adds: A+B>=128 for A in 1..4, B in 125..127 -> 9 vectors.
    // Subs: A-(-128)>=129 for every A -> 4 vectors. First in sweep order is
    // add A=1, B=0x7F (second vector).
    task automatic test_fault();
        int n;
        bit to;
        stuck_ovf = 1'b1;
        pulse_main();
        wait_done_main(n, to);
        total_cnt++;
        if (to || err_m !== 16'd13 || vec_m !== 16'd32)
            $display("FAIL fault_counts: got err=%0d vec=%0d (timeout=%b) want 13 32", err_m, vec_m, to);
        else pass_cnt++;
        total_cnt++;
        if (fa_m !== 8'h01 || fb_m !== 8'h7F || fop_m !== 1'b0)
            $display("FAIL fault_first: got a=%h b=%h op=%b want 01 7f 0", fa_m, fb_m, fop_m);
        else pass_cnt++;
        total_cnt++;
        if (pass_m !== 1'b0 || done_m !== 1'b1)
            $display("FAIL fault_pass: got pass=%b done=%b want 0 1", pass_m, done_m);
        else pass_cnt++;
        stuck_ovf = 1'b0;
    endtask

    task automatic test_reset_midsweep();
        int n;
        bit to;
        pulse_main();
        for (int i = 0; i < 9; i++) step();
        total_cnt++;
        if (vec_m !== 16'd3) $display("FAIL midsweep_progress: got vec=%0d want 3", vec_m);
        else pass_cnt++;
        rst = 1'b1;
        step();
        total_cnt++;
        if ({a_m, b_m, op_m, busy_m, done_m, pass_m, vec_m, err_m, fa_m, fb_m, fop_m} !== '0)
            $display("FAIL midsweep_reset: got a=%h b=%h busy=%b done=%b vec=%0d err=%0d, want all 0",
                     a_m, b_m, busy_m, done_m, vec_m, err_m);
        else pass_cnt++;
        rst = 1'b0;
        step();
        pulse_main();
        wait_done_main(n, to);
        total_cnt++;
        if (to || vec_m !== 16'd32 || pass_m !== 1'b1)
            $display("FAIL after_reset_sweep: got vec=%0d pass=%b (timeout=%b) want 32 1", vec_m, pass_m, to);
        else pass_cnt++;
    endtask

    task automatic test_restart();
        int n;
        bit to;
        pulse_main();
        for (int i = 0; i < 19; i++) step();
        pulse_main();   // while busy: must not restart
        wait_done_main(n, to);
        total_cnt++;
        if (to || (n + 21) != 97 || vec_m !== 16'd32)
            $display("FAIL ignore_busy_start: got %0d edges vec=%0d (timeout=%b) want 97 32", n + 21, vec_m, to);
        else pass_cnt++;
        pulse_main();   // from DONE: clears and reruns
        total_cnt++;
        if (done_m !== 1'b0 || pass_m !== 1'b0 || vec_m !== 16'd0 || busy_m !== 1'b1)
            $display("FAIL restart_clear: got done=%b pass=%b vec=%0d busy=%b want 0 0 0 1",
                     done_m, pass_m, vec_m, busy_m);
        else pass_cnt++;
        wait_done_main(n, to);
        total_cnt++;
        if (to || vec_m !== 16'd32 || pass_m !== 1'b1)
            $display("FAIL restart_sweep: got vec=%0d pass=%b (timeout=%b) want 32 1", vec_m, pass_m, to);
        else pass_cnt++;
    endtask

    task automatic test_wrap_grid();
        logic [7:0] bseq [3] = '{8'h01, 8'h00, 8'hFF};
        logic [7:0] ea;
        logic       eo;
        start_w = 1'b1;
        step();
        start_w = 1'b0;
        for (int v = 0; v < 24; v++) begin
            step();     // DRIVE edge
            eo = (v >= 12);
            ea = 8'(1 + (v % 12) / 3);
            total_cnt++;
            if (a_w !== ea || b_w !== bseq[v % 3] || op_w !== eo)
                $display("FAIL wrap_vec_%0d: got a=%h b=%h op=%b want a=%h b=%h op=%b",
                         v, a_w, b_w, op_w, ea, bseq[v % 3], eo);
            else pass_cnt++;
            step();     // CHECK edge
        end
        total_cnt++;
        if (done_w !== 1'b1 || vec_w !== 16'd24 || err_w !== 16'd0 || pass_w !== 1'b1)
            $display("FAIL wrap_final: got done=%b vec=%0d err=%0d pass=%b want 1 24 0 1",
                     done_w, vec_w, err_w, pass_w);
        else pass_cnt++;
    endtask

    task automatic test_empty_grid();
        start_e = 1'b1;
        step();
        start_e = 1'b0;
        step();
        total_cnt++;
        if (done_e !== 1'b1 || pass_e !== 1'b1 || vec_e !== 16'd0 || busy_e !== 1'b0)
            $display("FAIL empty_grid: got done=%b pass=%b vec=%0d busy=%b want 1 1 0 0",
                     done_e, pass_e, vec_e, busy_e);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_spot();
        test_clean_sweep();
        test_fault();
        test_reset_midsweep();
        test_restart();
        test_wrap_grid();
        test_empty_grid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
